// File: rtl/ddram_arbiter.sv
// ddram_arbiter: shares the DDRAM Avalon port between the cart loader writes and two cached 16-bit read clients
module ddram_arbiter #(
  parameter logic [28:0] BASE = 29'h6000000,
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [24:0] wr_addr,
  input  logic [15:0] wr_din,
  input  logic        wr_req,
  output logic        wr_ack,
  input  logic [24:1] rd0_addr,
  input  logic        rd0_req,
  output logic        rd0_ack,
  output logic [15:0] rd0_dout,
  input  logic [24:1] rd1_addr,
  input  logic        rd1_req,
  output logic        rd1_ack,
  output logic [15:0] rd1_dout,
  input  logic        DDRAM_BUSY,
  output logic [7:0]  DDRAM_BURSTCNT,
  output logic [28:0] DDRAM_ADDR,
  input  logic [63:0] DDRAM_DOUT,
  input  logic        DDRAM_DOUT_READY,
  output logic        DDRAM_RD,
  output logic [63:0] DDRAM_DIN,
  output logic [7:0]  DDRAM_BE,
  output logic        DDRAM_WE
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, WAIT} state_t;
  state_t state;
  logic [24:1] ra [2];
  logic [21:0] tag [2];
  logic [63:0] line [2];
  logic [15:0] dout [2];
  logic [1:0] req, ack, val, pend, match, hit, miss;
  logic gnt, rr, win, wpend, unused_ok;
  // drain survives reset so a read already accepted by DDRAM cannot land on a new request
  logic drain = 1'b0;
  assign ra[0] = rd0_addr;
  assign ra[1] = rd1_addr;
  assign req = {rd1_req, rd0_req};
  assign {rd1_ack, rd0_ack} = ack;
  assign rd0_dout = dout[0];
  assign rd1_dout = dout[1];
  assign DDRAM_BURSTCNT = 8'd1;
  assign wpend = wr_req != wr_ack;
  assign unused_ok = wr_addr[0];
  always_comb begin
    pend = '0;
    match = '0;
    hit = '0;
    miss = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = req[i] ^ ack[i];
      match[i] = val[i] && tag[i] == ra[i][24:3];
      hit[i] = pend[i] && match[i] && !((state == READ || state == WAIT) && gnt == i[0]);
      miss[i] = pend[i] && !match[i];
    end
    win = &miss ? (RR_ENABLE && rr) : !miss[0];
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      if (state == WAIT || (state == READ && !DDRAM_BUSY)) drain <= 1'b1;
      state <= IDLE;
      wr_ack <= 1'b0;
      ack <= '0;
      val <= '0;
      dout[0] <= '0;
      dout[1] <= '0;
      rr <= 1'b0;
      gnt <= 1'b0;
      DDRAM_RD <= 1'b0;
      DDRAM_WE <= 1'b0;
      DDRAM_ADDR <= '0;
      DDRAM_DIN <= '0;
      DDRAM_BE <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (hit[i]) begin
          dout[i] <= line[i][{ra[i][2:1], 4'd0} +: 16];
          ack[i] <= req[i];
        end
      if (drain && DDRAM_DOUT_READY) drain <= 1'b0;
      case (state)
        IDLE:
          if (!drain && wpend) begin
            DDRAM_WE <= 1'b1;
            DDRAM_ADDR <= BASE | {7'd0, wr_addr[24:3]};
            DDRAM_DIN <= {4{wr_din}};
            DDRAM_BE <= 8'b11 << {wr_addr[2:1], 1'b0};
            state <= WRITE;
          end else if (!drain && |miss) begin
            gnt <= win;
            rr <= &miss ? !win : rr;
            DDRAM_RD <= 1'b1;
            DDRAM_ADDR <= BASE | {7'd0, ra[win][24:3]};
            state <= READ;
          end
        WRITE:
          if (!DDRAM_BUSY) begin
            DDRAM_WE <= 1'b0;
            wr_ack <= wr_req;
            state <= IDLE;
            for (int i = 0; i < 2; i++)
              if (tag[i] == wr_addr[24:3]) val[i] <= 1'b0;
          end
        READ:
          if (!DDRAM_BUSY) begin
            DDRAM_RD <= 1'b0;
            state <= WAIT;
          end
        WAIT:
          if (DDRAM_DOUT_READY) begin
            line[gnt] <= DDRAM_DOUT;
            tag[gnt] <= ra[gnt][24:3];
            val[gnt] <= 1'b1;
            dout[gnt] <= DDRAM_DOUT[{ra[gnt][2:1], 4'd0} +: 16];
            ack[gnt] <= req[gnt];
            state <= IDLE;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_ddram_arbiter.sv
// tb_ddram_arbiter: directed scenario tests for ddram_arbiter with a one-cycle-latency DDRAM responder
module tb_ddram_arbiter;
  localparam logic [28:0] BASE = 29'h6000000;
  logic clk_sys = 1'b0, reset = 1'b1;
  logic [24:0] wr_addr = '0;
  logic [15:0] wr_din = '0;
  logic wr_req = 1'b0, wr_ack;
  logic [24:1] rd0_addr = '0, rd1_addr = '0;
  logic rd0_req = 1'b0, rd1_req = 1'b0, rd0_ack, rd1_ack;
  logic [15:0] rd0_dout, rd1_dout;
  logic busy = 1'b0, rd, we;
  logic [7:0] burstcnt, be;
  logic [28:0] ddr_addr;
  logic [63:0] rdata = '0, din;
  logic dr = 1'b0, man_rdy = 1'b0, acc = 1'b0, auto_en = 1'b1;
  logic [29:0] log_q [$];
  int passed = 0, total = 0;

  always #5 clk_sys = ~clk_sys;

  ddram_arbiter dut (
    .clk_sys(clk_sys), .reset(reset),
    .wr_addr(wr_addr), .wr_din(wr_din), .wr_req(wr_req), .wr_ack(wr_ack),
    .rd0_addr(rd0_addr), .rd0_req(rd0_req), .rd0_ack(rd0_ack), .rd0_dout(rd0_dout),
    .rd1_addr(rd1_addr), .rd1_req(rd1_req), .rd1_ack(rd1_ack), .rd1_dout(rd1_dout),
    .DDRAM_BUSY(busy), .DDRAM_BURSTCNT(burstcnt), .DDRAM_ADDR(ddr_addr),
    .DDRAM_DOUT(rdata), .DDRAM_DOUT_READY(dr | man_rdy), .DDRAM_RD(rd),
    .DDRAM_DIN(din), .DDRAM_BE(be), .DDRAM_WE(we)
  );

  // logs every accepted command and returns read data the cycle after a read is accepted
  always @(negedge clk_sys) begin
    if ((rd || we) && !busy) log_q.push_back({we, ddr_addr});
    dr = auto_en && acc;
    acc = rd && !busy;
  end

  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_all;
    for (int k = 0; k < 80 && (wr_ack !== wr_req || rd0_ack !== rd0_req || rd1_ack !== rd1_req); k++) tick;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    total++; if ({wr_ack, rd0_ack, rd1_ack} !== 3'b000) $display("FAIL reset_acks got %b want 000", {wr_ack, rd0_ack, rd1_ack}); else passed++;
    total++; if ({rd0_dout, rd1_dout} !== 32'h0) $display("FAIL reset_dout got %h want 0", {rd0_dout, rd1_dout}); else passed++;
    total++; if ({rd, we} !== 2'b00) $display("FAIL reset_cmd got %b want 00", {rd, we}); else passed++;
    total++; if ({ddr_addr, din, be} !== 101'h0) $display("FAIL reset_bus got %h %h %h want 0", ddr_addr, din, be); else passed++;
    total++; if (burstcnt !== 8'd1) $display("FAIL reset_burstcnt got %0d want 1", burstcnt); else passed++;
  endtask

  task automatic test_read_hit;
    logic [29:0] e;
    rdata = 64'h4444_3333_2222_1111;
    log_q.delete();
    rd0_addr = 24'h000100;
    rd0_req = ~rd0_req;
    wait_all;
    total++; if (rd0_ack !== rd0_req) $display("FAIL miss_ack got %b want %b", rd0_ack, rd0_req); else passed++;
    total++; if (rd0_dout !== 16'h1111) $display("FAIL miss_dout got %h want 1111", rd0_dout); else passed++;
    e = log_q.size() == 1 ? log_q[0] : '1;
    total++; if (e !== {1'b0, BASE | 29'h40}) $display("FAIL miss_cmd got %h want %h", e, {1'b0, BASE | 29'h40}); else passed++;
    rd0_addr = 24'h000103;
    rd0_req = ~rd0_req;
    tick;
    total++; if (rd0_ack !== rd0_req) $display("FAIL hit_ack got %b want %b", rd0_ack, rd0_req); else passed++;
    total++; if (rd0_dout !== 16'h4444) $display("FAIL hit_dout got %h want 4444", rd0_dout); else passed++;
    tick;
    total++; if (rd !== 1'b0 || log_q.size() != 1) $display("FAIL hit_no_rd got rd=%b cmds=%0d want rd=0 cmds=1", rd, log_q.size()); else passed++;
  endtask

  task automatic test_write;
    int n = 0;
    logic [7:0] be_s = '0;
    logic [63:0] din_s = '0;
    logic [28:0] addr_s = '0;
    busy = 1'b1;
    wr_addr = 25'h000006;
    wr_din = 16'hBEEF;
    wr_req = ~wr_req;
    for (int k = 0; k < 8; k++) begin
      tick;
      if (we) n++;
      if (k == 0) begin
        be_s = be;
        din_s = din;
        addr_s = ddr_addr;
      end
      if (k == 3) busy = 1'b0;
    end
    total++; if (n != 4) $display("FAIL wr_we_cycles got %0d want 4", n); else passed++;
    total++; if (be_s !== 8'hC0) $display("FAIL wr_be got %h want c0", be_s); else passed++;
    total++; if (din_s !== 64'hBEEF_BEEF_BEEF_BEEF) $display("FAIL wr_din got %h want beefbeefbeefbeef", din_s); else passed++;
    total++; if (addr_s !== BASE) $display("FAIL wr_addr got %h want %h", addr_s, BASE); else passed++;
    total++; if (wr_ack !== wr_req) $display("FAIL wr_ack got %b want %b", wr_ack, wr_req); else passed++;
  endtask

  task automatic test_invalidate;
    rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    rd0_addr = 24'h000000;
    rd0_req = ~rd0_req;
    wait_all;
    total++; if (rd0_dout !== 16'hDDDD) $display("FAIL inv_fill got %h want dddd", rd0_dout); else passed++;
    wr_addr = 25'h000002;
    wr_din = 16'h1234;
    wr_req = ~wr_req;
    wait_all;
    total++; if (wr_ack !== wr_req) $display("FAIL inv_wr_ack got %b want %b", wr_ack, wr_req); else passed++;
    rdata = 64'h0005_0006_0007_0008;
    log_q.delete();
    rd0_addr = 24'h000001;
    rd0_req = ~rd0_req;
    wait_all;
    total++; if (log_q.size() != 1) $display("FAIL inv_reread_rd got %0d cmds want 1", log_q.size()); else passed++;
    total++; if (rd0_dout !== 16'h0007) $display("FAIL inv_reread_dout got %h want 0007", rd0_dout); else passed++;
  endtask

  task automatic test_arbitration;
    logic [29:0] e0, e1, e2;
    rdata = 64'h0000_0000_0000_0001;
    log_q.delete();
    rd0_addr = 24'h001000;
    rd1_addr = 24'h002000;
    wr_addr = 25'h000400;
    wr_req = ~wr_req;
    rd0_req = ~rd0_req;
    rd1_req = ~rd1_req;
    wait_all;
    total++; if ({wr_ack, rd0_ack, rd1_ack} !== {wr_req, rd0_req, rd1_req}) $display("FAIL arb_acks got %b want %b", {wr_ack, rd0_ack, rd1_ack}, {wr_req, rd0_req, rd1_req}); else passed++;
    e0 = log_q.size() == 3 ? log_q[0] : '1;
    e1 = log_q.size() == 3 ? log_q[1] : '1;
    e2 = log_q.size() == 3 ? log_q[2] : '1;
    total++; if (e0 !== {1'b1, BASE | 29'h80}) $display("FAIL arb_first got %h want %h", e0, {1'b1, BASE | 29'h80}); else passed++;
    total++; if (e1 !== {1'b0, BASE | 29'h400}) $display("FAIL arb_second got %h want %h", e1, {1'b0, BASE | 29'h400}); else passed++;
    total++; if (e2 !== {1'b0, BASE | 29'h800}) $display("FAIL arb_third got %h want %h", e2, {1'b0, BASE | 29'h800}); else passed++;
    log_q.delete();
    rd0_addr = 24'h003000;
    rd1_addr = 24'h004000;
    rd0_req = ~rd0_req;
    rd1_req = ~rd1_req;
    wait_all;
    total++; if ({rd0_ack, rd1_ack} !== {rd0_req, rd1_req}) $display("FAIL rr_acks got %b want %b", {rd0_ack, rd1_ack}, {rd0_req, rd1_req}); else passed++;
    e0 = log_q.size() == 2 ? log_q[0] : '1;
    e1 = log_q.size() == 2 ? log_q[1] : '1;
    total++; if (e0 !== {1'b0, BASE | 29'h1000}) $display("FAIL rr_first got %h want %h", e0, {1'b0, BASE | 29'h1000}); else passed++;
    total++; if (e1 !== {1'b0, BASE | 29'hC00}) $display("FAIL rr_second got %h want %h", e1, {1'b0, BASE | 29'hC00}); else passed++;
  endtask

  task automatic test_reset_drain;
    int n = 0;
    auto_en = 1'b0;
    rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    rd0_addr = 24'h005000;
    rd0_req = ~rd0_req;
    for (int k = 0; k < 20 && rd !== 1'b1; k++) tick;
    total++; if (rd !== 1'b1) $display("FAIL drain_rd_issued got %b want 1", rd); else passed++;
    tick;
    reset = 1'b1;
    wr_req = 1'b0;
    rd0_req = 1'b0;
    rd1_req = 1'b0;
    tick;
    reset = 1'b0;
    total++; if ({rd, we, rd0_ack} !== 3'b000) $display("FAIL drain_after_reset got %b want 000", {rd, we, rd0_ack}); else passed++;
    rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    rd0_addr = 24'h006000;
    rd0_req = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick;
      if (rd) n++;
    end
    man_rdy = 1'b1;
    tick;
    man_rdy = 1'b0;
    total++; if (n != 0) $display("FAIL drain_no_grant got %0d rd cycles want 0", n); else passed++;
    total++; if (rd0_ack !== 1'b0) $display("FAIL drain_stray_ack got %b want 0", rd0_ack); else passed++;
    rdata = 64'h7777_6666_5555_4444;
    auto_en = 1'b1;
    wait_all;
    total++; if (rd0_ack !== rd0_req) $display("FAIL drain_new_ack got %b want %b", rd0_ack, rd0_req); else passed++;
    total++; if (rd0_dout !== 16'h4444) $display("FAIL drain_new_dout got %h want 4444", rd0_dout); else passed++;
  endtask

  task automatic test_hit_during_miss;
    rdata = 64'h0123_4567_89AB_CDEF;
    rd0_addr = 24'h006002;
    rd1_addr = 24'h007000;
    rd0_req = ~rd0_req;
    rd1_req = ~rd1_req;
    tick;
    total++; if (rd0_ack !== rd0_req) $display("FAIL hm_hit_ack got %b want %b", rd0_ack, rd0_req); else passed++;
    total++; if (rd0_dout !== 16'h6666) $display("FAIL hm_hit_dout got %h want 6666", rd0_dout); else passed++;
    total++; if (rd1_ack !== ~rd1_req) $display("FAIL hm_miss_pending got %b want %b", rd1_ack, ~rd1_req); else passed++;
    total++; if (rd !== 1'b1) $display("FAIL hm_miss_rd got %b want 1", rd); else passed++;
    wait_all;
    total++; if (rd1_ack !== rd1_req) $display("FAIL hm_miss_ack got %b want %b", rd1_ack, rd1_req); else passed++;
    total++; if (rd1_dout !== 16'hCDEF) $display("FAIL hm_miss_dout got %h want cdef", rd1_dout); else passed++;
  endtask

  initial begin
    test_reset;
    test_read_hit;
    test_write;
    test_invalidate;
    test_arbitration;
    test_reset_drain;
    test_hit_during_miss;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
